// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: widths, ALU op codes, FSM states.
// Holds the single-cycle ALU as a pure function so the stage stays readable.
// No state lives here; everything is combinational.
package ex_stage_pkg;

    localparam int XLEN       = 32;
    localparam int MUL_CYCLES = 32;
    localparam int MUL_CNT_W  = $clog2(MUL_CYCLES);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASS  = 4'd10,
        ALU_MUL   = 4'd11,
        ALU_MULHU = 4'd12
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_e;

    // Single-cycle ALU. Multiply codes and unknown codes yield 0; the stage
    // routes multiplies to the iterative unit when that unit is built.
    function automatic logic [XLEN-1:0] alu_compute(
        input logic [3:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [4:0] shamt;
        shamt = b[4:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << shamt;
            ALU_SRL:  return a >> shamt;
            ALU_SRA:  return $unsigned($signed(a) >>> shamt);
            ALU_SLT:  return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
            ALU_PASS: return b;
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add unsigned 32x32->64 multiplier, one bit per cycle.
// Latency: MUL_CYCLES edges after the start edge; done flags the final edge.
// Backpressure: hold freezes all state; clear abandons the operation.
// Built only when EX_MULDIV_EN is defined.
`ifdef EX_MULDIV_EN
module ex_mul_iter
    import ex_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 clear,
    input  logic                 hold,
    input  logic [XLEN-1:0]      a,
    input  logic [XLEN-1:0]      b,
    output logic                 busy,
    output logic                 done,
    output logic [2*XLEN-1:0]    product
);

    logic                 busy_q, busy_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]      mcand_q, mcand_d;
    logic [2*XLEN-1:0]    prod_q, prod_d;
    logic [XLEN:0]        sum;
    logic                 last_iter;

    // Next-state: clear beats hold beats start beats iterate. The low half of
    // prod holds the remaining multiplier bits and shifts out as the high half fills.
    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        sum       = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        last_iter = (cnt_q == MUL_CNT_W'(MUL_CYCLES - 1));
        if (clear) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (hold) begin
            busy_d = busy_q;
        end else if (start) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            mcand_d = a;
            prod_d  = {{XLEN{1'b0}}, b};
        end else if (busy_q) begin
            prod_d = {sum, prod_q[XLEN-1:1]};
            cnt_d  = last_iter ? '0 : cnt_q + 1'b1;
            busy_d = ~last_iter;
        end
    end

    // Done marks the edge that completes the final iteration; product shows
    // the value being loaded, so it is final exactly when done is high.
    assign done    = busy_q & ~clear & ~hold & last_iter;
    assign busy    = busy_q;
    assign product = prod_d;

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: ALU result and op_1+mem_offset registered into the EX/MEM boundary.
// Latency 1 edge for ALU ops; MUL/MULHU take 33 edges (accept edge included).
// stall_i freezes every register; stall_req holds upstream while multiplying (EX_MULDIV_EN).
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] op_1,
    input  logic [XLEN-1:0] op_2,
    input  logic [4:0]      rd_addr,
    input  logic            rd_we,
    input  logic [XLEN-1:0] mem_offset,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] pc_in,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            stall_req,
    output logic            valid_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic            rd_we_q, rd_we_d;
    logic [XLEN-1:0] pc_q, pc_d;

`ifdef EX_MULDIV_EN
    ex_state_e         state_q, state_d;
    logic              mul_hi_q, mul_hi_d;
    logic              mul_rd_we_q, mul_rd_we_d;
    logic              mul_start, mul_busy, mul_done, is_mul;
    logic [2*XLEN-1:0] mul_product;

    ex_mul_iter u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .clear   (flush_i),
        .hold    (stall_i),
        .a       (op_1),
        .b       (op_2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign is_mul    = (alu_op == ALU_MUL) || (alu_op == ALU_MULHU);
    assign stall_req = (state_q == ST_MUL);
`else
    assign stall_req = 1'b0;
`endif

    // Next-state for the EX/MEM registers: flush > stall > finish/accept.
    always_comb begin
        valid_d    = valid_q;
        result_d   = result_q;
        mem_addr_d = mem_addr_q;
        rd_addr_d  = rd_addr_q;
        rd_we_d    = rd_we_q;
        pc_d       = pc_q;
`ifdef EX_MULDIV_EN
        state_d     = state_q;
        mul_hi_d    = mul_hi_q;
        mul_rd_we_d = mul_rd_we_q;
        mul_start   = 1'b0;
`endif
        if (flush_i) begin
            valid_d = 1'b0;
            rd_we_d = 1'b0;
`ifdef EX_MULDIV_EN
            state_d = ST_IDLE;
`endif
        end else if (stall_i) begin
            valid_d = valid_q;
`ifdef EX_MULDIV_EN
        end else if (state_q == ST_MUL) begin
            // Sidebands were captured at accept; only result and valid land now.
            if (mul_done) begin
                valid_d  = 1'b1;
                rd_we_d  = mul_rd_we_q;
                result_d = mul_hi_q ? mul_product[2*XLEN-1:XLEN] : mul_product[XLEN-1:0];
                state_d  = ST_IDLE;
            end else if (!mul_busy) begin
                state_d = ST_IDLE;
            end
`endif
        end else if (in_valid) begin
            mem_addr_d = op_1 + mem_offset;
            rd_addr_d  = rd_addr;
            pc_d       = pc_in;
`ifdef EX_MULDIV_EN
            if (is_mul) begin
                // Bubble while iterating; write enable parked until completion.
                mul_start   = 1'b1;
                valid_d     = 1'b0;
                rd_we_d     = 1'b0;
                mul_hi_d    = (alu_op == ALU_MULHU);
                mul_rd_we_d = rd_we;
                state_d     = ST_MUL;
            end else begin
                valid_d  = 1'b1;
                rd_we_d  = rd_we;
                result_d = alu_compute(alu_op, op_1, op_2);
            end
`else
            valid_d  = 1'b1;
            rd_we_d  = rd_we;
            result_d = alu_compute(alu_op, op_1, op_2);
`endif
        end else begin
            valid_d = 1'b0;
            rd_we_d = 1'b0;
        end
    end

    // EX/MEM boundary and FSM registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            mem_addr_q <= '0;
            rd_addr_q  <= '0;
            rd_we_q    <= 1'b0;
            pc_q       <= '0;
`ifdef EX_MULDIV_EN
            state_q     <= ST_IDLE;
            mul_hi_q    <= 1'b0;
            mul_rd_we_q <= 1'b0;
`endif
        end else begin
            valid_q    <= valid_d;
            result_q   <= result_d;
            mem_addr_q <= mem_addr_d;
            rd_addr_q  <= rd_addr_d;
            rd_we_q    <= rd_we_d;
            pc_q       <= pc_d;
`ifdef EX_MULDIV_EN
            state_q     <= state_d;
            mul_hi_q    <= mul_hi_d;
            mul_rd_we_q <= mul_rd_we_d;
`endif
        end
    end

    assign valid_o      = valid_q;
    assign alu_result_o = result_q;
    assign mem_addr_o   = mem_addr_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_we_o      = rd_we_q;
    assign pc_o         = pc_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with a scoreboard of expected EX/MEM entries.
// Expected entries are queued when an instruction is driven, checked when valid_o rises.
// Multiplier scenarios run only when EX_MULDIV_EN is defined.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] op_1, op_2, mem_offset, pc_in;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [3:0]  alu_op;
    logic        stall_i, flush_i;
    logic        stall_req, valid_o, rd_we_o;
    logic [31:0] alu_result_o, mem_addr_o, pc_o;
    logic [4:0]  rd_addr_o;

    typedef struct {
        logic [31:0] res;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ex_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .op_1         (op_1),
        .op_2         (op_2),
        .rd_addr      (rd_addr),
        .rd_we        (rd_we),
        .mem_offset   (mem_offset),
        .alu_op       (alu_op),
        .pc_in        (pc_in),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .stall_req    (stall_req),
        .valid_o      (valid_o),
        .alu_result_o (alu_result_o),
        .mem_addr_o   (mem_addr_o),
        .rd_addr_o    (rd_addr_o),
        .rd_we_o      (rd_we_o),
        .pc_o         (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] off, input logic [4:0] rd, input logic we,
                         input logic [31:0] pc, input logic [31:0] exp_res, input bit push);
        exp_t e;
        in_valid   = 1'b1;
        alu_op     = op;
        op_1       = a;
        op_2       = b;
        mem_offset = off;
        rd_addr    = rd;
        rd_we      = we;
        pc_in      = pc;
        if (push) begin
            e.res  = exp_res;
            e.addr = a + off;
            e.pc   = pc;
            e.rd   = rd;
            e.we   = we;
            sb.push_back(e);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, ".valid"}, 32'(valid_o), 32'd1);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s.sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".res"},  alu_result_o,    e.res);
            check({tag, ".addr"}, mem_addr_o,      e.addr);
            check({tag, ".rd"},   32'(rd_addr_o),  32'(e.rd));
            check({tag, ".we"},   32'(rd_we_o),    32'(e.we));
            check({tag, ".pc"},   pc_o,            e.pc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 32'(valid_o),     32'd0);
        check({tag, ".res"},   alu_result_o,     32'd0);
        check({tag, ".addr"},  mem_addr_o,       32'd0);
        check({tag, ".rd"},    32'(rd_addr_o),   32'd0);
        check({tag, ".we"},    32'(rd_we_o),     32'd0);
        check({tag, ".pc"},    pc_o,             32'd0);
        check({tag, ".sreq"},  32'(stall_req),   32'd0);
    endtask

`ifdef EX_MULDIV_EN
    // Accept one multiply, optionally stall mid-iteration, count edges to valid_o.
    task automatic run_mul(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res,
                           input int stall_at, input int stall_len, input int exp_edges);
        int edges;
        int sreq_low;
        drive(op, a, b, 32'h10, 5'd7, 1'b1, 32'h200, exp_res, 1'b1);
        step();
        edges    = 1;
        in_valid = 1'b0;
        check({tag, ".bubble"}, 32'(valid_o), 32'd0);
        sreq_low = 0;
        while (valid_o !== 1'b1 && edges < 200) begin
            if (stall_req !== 1'b1) sreq_low++;
            stall_i = (edges >= stall_at) && (edges < stall_at + stall_len);
            step();
            edges++;
        end
        stall_i = 1'b0;
        check({tag, ".edges"}, 32'(edges), 32'(exp_edges));
        check({tag, ".sreq_held"}, 32'(sreq_low), 32'd0);
        check({tag, ".sreq_drop"}, 32'(stall_req), 32'd0);
        pop_check(tag);
    endtask
`endif

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        op_1       = '0;
        op_2       = '0;
        mem_offset = '0;
        rd_addr    = '0;
        rd_we      = 1'b0;
        alu_op     = '0;
        pc_in      = '0;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        #2;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // ALU ops back to back, one result per edge.
        drive(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h4, 5'd1, 1'b1, 32'h100, 32'h0, 1'b1);
        step(); pop_check("add_wrap");
        check("add_wrap.sreq", 32'(stall_req), 32'd0);
        drive(ALU_SRA, 32'h8000_0000, 32'h24, 32'h0, 5'd2, 1'b1, 32'h104, 32'hF800_0000, 1'b1);
        step(); pop_check("sra");
        drive(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h8, 5'd3, 1'b1, 32'h108, 32'h1, 1'b1);
        step(); pop_check("slt");
        drive(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h8, 5'd4, 1'b1, 32'h10C, 32'h0, 1'b1);
        step(); pop_check("sltu");
        drive(ALU_SUB, 32'h5, 32'h7, 32'h0, 5'd5, 1'b1, 32'h110, 32'hFFFF_FFFE, 1'b1);
        step(); pop_check("sub");
        drive(ALU_AND, 32'hF0F0_1234, 32'hFF00_FF00, 32'h0, 5'd6, 1'b0, 32'h114, 32'hF000_1200, 1'b1);
        step(); pop_check("and");
        drive(ALU_OR, 32'hF0F0_0000, 32'h0F00_000F, 32'h0, 5'd7, 1'b1, 32'h118, 32'hFFF0_000F, 1'b1);
        step(); pop_check("or");
        drive(ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h0, 5'd8, 1'b1, 32'h11C, 32'h5555_5555, 1'b1);
        step(); pop_check("xor");
        drive(ALU_SLL, 32'h1, 32'h3F, 32'h0, 5'd9, 1'b1, 32'h120, 32'h8000_0000, 1'b1);
        step(); pop_check("sll");
        drive(ALU_SRL, 32'h8000_0000, 32'h21, 32'h0, 5'd10, 1'b1, 32'h124, 32'h4000_0000, 1'b1);
        step(); pop_check("srl");
        drive(ALU_PASS, 32'h1234_5678, 32'hABCD_E000, 32'h0, 5'd11, 1'b1, 32'h128, 32'hABCD_E000, 1'b1);
        step(); pop_check("pass");
        drive(4'd15, 32'h1234_5678, 32'h9, 32'h0, 5'd12, 1'b1, 32'h12C, 32'h0, 1'b1);
        step(); pop_check("undef");
`ifndef EX_MULDIV_EN
        drive(ALU_MUL, 32'h3, 32'h5, 32'h0, 5'd13, 1'b1, 32'h130, 32'h0, 1'b1);
        step(); pop_check("mul_off");
        check("mul_off.sreq", 32'(stall_req), 32'd0);
        drive(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5'd14, 1'b1, 32'h134, 32'h0, 1'b1);
        step(); pop_check("mulhu_off");
`endif

        // Idle cycle: bubble with write enable forced low.
        in_valid = 1'b0;
        step();
        check("idle.valid", 32'(valid_o), 32'd0);
        check("idle.we", 32'(rd_we_o), 32'd0);

        // Downstream stall holds outputs; the waiting instruction lands after release.
        drive(ALU_ADD, 32'd10, 32'd20, 32'h40, 5'd3, 1'b1, 32'h200, 32'd30, 1'b1);
        step(); pop_check("pre_stall");
        drive(ALU_SUB, 32'd50, 32'd8, 32'h80, 5'd4, 1'b1, 32'h204, 32'd42, 1'b1);
        stall_i = 1'b1;
        step();
        check("stall.valid", 32'(valid_o), 32'd1);
        check("stall.res", alu_result_o, 32'd30);
        check("stall.addr", mem_addr_o, 32'h4A);
        stall_i = 1'b0;
        step(); pop_check("post_stall");

        // Flush kills the offered instruction; the next one has latency 1.
        drive(ALU_ADD, 32'd7, 32'd8, 32'h0, 5'd9, 1'b1, 32'h300, 32'd15, 1'b0);
        flush_i = 1'b1;
        step();
        check("flush.valid", 32'(valid_o), 32'd0);
        check("flush.we", 32'(rd_we_o), 32'd0);
        flush_i = 1'b0;
        drive(ALU_ADD, 32'd2, 32'd3, 32'h0, 5'd9, 1'b1, 32'h304, 32'd5, 1'b1);
        step(); pop_check("after_flush");

`ifdef EX_MULDIV_EN
        run_mul("mul", ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 0, 0, 33);
        run_mul("mulhu", ALU_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h1, 0, 0, 33);
        run_mul("mulhu_max", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 33);
        run_mul("mul_max", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 0, 0, 33);
        run_mul("mul_stall", ALU_MUL, 32'd1234, 32'd5678, 32'd7006652, 10, 5, 38);

        // Flush at iteration 10 abandons the multiply.
        drive(ALU_MUL, 32'd3, 32'd4, 32'h0, 5'd5, 1'b1, 32'h400, 32'd12, 1'b0);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mflush.sreq_before", 32'(stall_req), 32'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("mflush.valid", 32'(valid_o), 32'd0);
        check("mflush.sreq", 32'(stall_req), 32'd0);
        drive(ALU_ADD, 32'd2, 32'd3, 32'h0, 5'd6, 1'b1, 32'h404, 32'd5, 1'b1);
        step(); pop_check("mflush_add");
        in_valid = 1'b0;

        // Park in the middle of a multiply before the asynchronous reset.
        drive(ALU_MUL, 32'd9, 32'd9, 32'h0, 5'd5, 1'b1, 32'h500, 32'd81, 1'b0);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
`else
        // Leave a live entry in the boundary before the asynchronous reset.
        drive(ALU_ADD, 32'd9, 32'd9, 32'h8, 5'd5, 1'b1, 32'h500, 32'd18, 1'b0);
        step();
        in_valid = 1'b0;
`endif
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;

        // Load address generation after reset: wraps to 0x0FFC.
        drive(ALU_ADD, 32'h1000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 5'd10, 1'b1, 32'h600, 32'h0FFC, 1'b1);
        step(); pop_check("load_addr");
        check("load_addr.abs", mem_addr_o, 32'h0000_0FFC);
        in_valid = 1'b0;
        step();
        check("final.sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
